// File: rtl/bcom_tx_arb.sv
// Frame-level arbiter and byte sequencer for the shared RS232 transmitter.
// Two requesters, round-robin on contention, watchdog on a silent transmitter.
module bcom_tx_arb #(
    parameter int P_TOUT = 1024
) (
    input  logic       clk,
    input  logic       ic_rst,
    input  logic [1:0] ic_req,
    input  logic [7:0] id_dw0,
    input  logic [7:0] id_dw1,
    input  logic [1:0] ic_last,
    input  logic       ic_txbusy,
    output logic       oc_txena,
    output logic [7:0] od_txdw,
    output logic [1:0] oc_gnt,
    output logic [1:0] oc_ack,
    output logic       od_err,
    output logic [2:0] od_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SEND  = 3'd2,
        S_WBUSY = 3'd3,
        S_WDONE = 3'd4,
        S_ACK   = 3'd5
    } state_t;

    localparam logic [15:0] TOUT_M1 = 16'(P_TOUT - 1);

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic        lserv_q, lserv_d;
    logic        last_q, last_d;
    logic [7:0]  txdw_q, txdw_d;
    logic        err_q, err_d;
    logic [15:0] wdog_q, wdog_d;

    logic [1:0]  sel_oh;
    logic [7:0]  dw_sel;
    logic [15:0] wdog_inc;

    assign sel_oh   = sel_q ? 2'b10 : 2'b01;
    assign dw_sel   = sel_q ? id_dw1 : id_dw0;
    assign wdog_inc = wdog_q + 16'd1;

    always_ff @(posedge clk) begin
        if (ic_rst) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            lserv_q <= 1'b1;
            last_q  <= 1'b0;
            txdw_q  <= 8'h00;
            err_q   <= 1'b0;
            wdog_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            lserv_q <= lserv_d;
            last_q  <= last_d;
            txdw_q  <= txdw_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        lserv_d  = lserv_q;
        last_d   = last_q;
        txdw_d   = txdw_q;
        err_d    = err_q;
        wdog_d   = wdog_q;
        oc_txena = 1'b0;
        oc_ack   = 2'b00;
        oc_gnt   = sel_oh;
        unique case (state_q)
            S_IDLE: begin
                oc_gnt = 2'b00;
                // On contention, serve whoever was not served last
                unique case (ic_req)
                    2'b01: begin sel_d = 1'b0;     state_d = S_LOAD; end
                    2'b10: begin sel_d = 1'b1;     state_d = S_LOAD; end
                    2'b11: begin sel_d = ~lserv_q; state_d = S_LOAD; end
                    default: ;
                endcase
            end
            S_LOAD: begin
                if (!ic_req[sel_q]) begin
                    state_d = S_IDLE;
                end else begin
                    txdw_d  = dw_sel;
                    last_d  = ic_last[sel_q];
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                oc_txena = 1'b1;
                wdog_d   = 16'd0;
                state_d  = S_WBUSY;
            end
            S_WBUSY: begin
                if (ic_txbusy) begin
                    state_d = S_WDONE;
                end else begin
                    wdog_d = wdog_inc;
                    // Abort the frame when the count reaches P_TOUT-1
                    if (wdog_inc == TOUT_M1) begin
                        err_d   = 1'b1;
                        lserv_d = sel_q;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WDONE: begin
                if (!ic_txbusy) state_d = S_ACK;
            end
            S_ACK: begin
                oc_ack = sel_oh;
                if (last_q) begin
                    lserv_d = sel_q;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign od_txdw  = txdw_q;
    assign od_err   = err_q;
    assign od_state = state_q;

endmodule
